// File: rtl/rgb2y_stream_if.sv
// Pixel stream bundle for rgb2y_stream: RGB888 input side and luma output side.
interface rgb2y_stream_if;
  logic        din_valid;
  logic [23:0] din;
  logic        din_sof;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_sof;
  logic        dout_eol;
  logic        dout_eof;

  // Converter side: consumes RGB pixels, produces luma pixels with frame flags
  modport slave (
    input  din_valid, din, din_sof,
    output dout, dout_valid, dout_sof, dout_eol, dout_eof
  );

  // Environment side: drives RGB pixels, observes luma pixels
  modport master (
    output din_valid, din, din_sof,
    input  dout, dout_valid, dout_sof, dout_eol, dout_eof
  );
endinterface

// File: rtl/rgb2y_stream.sv
// rgb2y_stream: converts an RGB888 pixel stream to 8-bit BT.601 luma through a
// fixed 3-stage pipeline, tracks frame position from din_sof, tags each pixel
// with sof/eol/eof and keeps a sticky framing-error flag.
module rgb2y_stream #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic          clk,
  input  logic          nrst,
  rgb2y_stream_if.slave pix,
  input  logic          err_clr,
  output logic          frame_err
);

  localparam logic [9:0] HLAST = 10'(WIDTH - 1);
  localparam logic [8:0] VLAST = 9'(HEIGHT - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e      state_q;
  logic [9:0]  h_cnt_q;
  logic [8:0]  v_cnt_q;
  logic        frame_err_q;

  logic        accept;
  logic        err_set;
  logic [9:0]  pos_h;
  logic [8:0]  pos_v;
  logic        pos_eol;
  logic        pos_eof;

  logic [15:0] prod_r_d;
  logic [15:0] prod_g_d;
  logic [15:0] prod_b_d;
  logic [16:0] sum_d;

  logic [15:0] prod_r_q;
  logic [15:0] prod_g_q;
  logic [15:0] prod_b_q;
  logic        s1_valid_q;
  logic        s1_sof_q;
  logic        s1_eol_q;
  logic        s1_eof_q;

  logic [16:0] sum_q;
  logic        s2_valid_q;
  logic        s2_sof_q;
  logic        s2_eol_q;
  logic        s2_eof_q;

  logic [7:0]  dout_q;
  logic        dout_valid_q;
  logic        dout_sof_q;
  logic        dout_eol_q;
  logic        dout_eof_q;

  // Decide whether the incoming pixel enters the pipeline and where it lands in the frame;
  // a start-of-frame pixel always sits at (0,0) regardless of the running counters
  always_comb begin
    accept  = pix.din_valid & (pix.din_sof | (state_q == ACTIVE));
    err_set = pix.din_valid & (pix.din_sof ? (state_q == ACTIVE) : (state_q == IDLE));
    pos_h   = pix.din_sof ? 10'd0 : h_cnt_q;
    pos_v   = pix.din_sof ? 9'd0 : v_cnt_q;
    pos_eol = (pos_h == HLAST);
    pos_eof = pos_eol & (pos_v == VLAST);
  end

  // Frame-position FSM: advances h/v on every accepted pixel and owns the sticky error flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      h_cnt_q     <= 10'd0;
      v_cnt_q     <= 9'd0;
      frame_err_q <= 1'b0;
    end else begin
      if (err_set) begin
        frame_err_q <= 1'b1;
      end else if (err_clr) begin
        frame_err_q <= 1'b0;
      end
      if (accept) begin
        if (pos_eof) begin
          h_cnt_q <= 10'd0;
          v_cnt_q <= 9'd0;
          state_q <= IDLE;
        end else if (pos_eol) begin
          h_cnt_q <= 10'd0;
          v_cnt_q <= pos_v + 9'd1;
          state_q <= ACTIVE;
        end else begin
          h_cnt_q <= pos_h + 10'd1;
          v_cnt_q <= pos_v;
          state_q <= ACTIVE;
        end
      end
    end
  end

  // Luma coefficient products and rounded sum; the sum never exceeds 65408 so bit 16 stays clear
  always_comb begin
    prod_r_d = 16'(pix.din[23:16]) * 16'd77;
    prod_g_d = 16'(pix.din[15:8]) * 16'd150;
    prod_b_d = 16'(pix.din[7:0]) * 16'd29;
    sum_d    = 17'(prod_r_q) + 17'(prod_g_q) + 17'(prod_b_q) + 17'd128;
  end

  // Stage 1: capture products and the position flags of the accepted pixel
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prod_r_q   <= 16'd0;
      prod_g_q   <= 16'd0;
      prod_b_q   <= 16'd0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_sof_q   <= accept & pix.din_sof;
      s1_eol_q   <= accept & pos_eol;
      s1_eof_q   <= accept & pos_eof;
      if (accept) begin
        prod_r_q <= prod_r_d;
        prod_g_q <= prod_g_d;
        prod_b_q <= prod_b_d;
      end
    end
  end

  // Stage 2: capture the rounded weighted sum
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sum_q      <= 17'd0;
      s2_valid_q <= 1'b0;
      s2_sof_q   <= 1'b0;
      s2_eol_q   <= 1'b0;
      s2_eof_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_sof_q   <= s1_sof_q;
      s2_eol_q   <= s1_eol_q;
      s2_eof_q   <= s1_eof_q;
      if (s1_valid_q) begin
        sum_q <= sum_d;
      end
    end
  end

  // Stage 3: output register; luma only updates on valid pixels so it holds across bubbles
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dout_q       <= 8'd0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
      dout_eol_q   <= 1'b0;
      dout_eof_q   <= 1'b0;
    end else begin
      dout_valid_q <= s2_valid_q;
      dout_sof_q   <= s2_sof_q;
      dout_eol_q   <= s2_eol_q;
      dout_eof_q   <= s2_eof_q;
      if (s2_valid_q) begin
        dout_q <= 8'(sum_q >> 8);
      end
    end
  end

  assign pix.dout       = dout_q;
  assign pix.dout_valid = dout_valid_q;
  assign pix.dout_sof   = dout_sof_q;
  assign pix.dout_eol   = dout_eol_q;
  assign pix.dout_eof   = dout_eof_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_rgb2y_stream.sv
// tb_rgb2y_stream: three converters with different frame geometries share one
// input stream; a frame-position reference model predicts every output cycle.
module tb_rgb2y_stream;

  localparam int WA = 4;
  localparam int HA = 2;
  localparam int WB = 3;
  localparam int HB = 1;
  localparam int WC = 16;
  localparam int HC = 12;

  typedef struct packed {
    logic       v;
    logic [7:0] y;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        dinValid;
  logic [23:0] dinData;
  logic        dinSof;
  logic        errClr;
  logic        checkEn;

  logic        errA;
  logic        errB;
  logic        errC;

  int          assertCount = 0;
  int          failCount   = 0;

  logic [7:0]  obsY   [3];
  logic        obsV   [3];
  logic        obsSof [3];
  logic        obsEol [3];
  logic        obsEof [3];
  logic        obsErr [3];

  int          eolCnt [3];
  int          eofCnt [3];
  int          sofCnt [3];

  logic        inFrame [3];
  int          pos     [3];
  logic        expErr  [3];
  logic [7:0]  heldY   [3];
  exp_t        hist    [3][3];

  rgb2y_stream_if ifA ();
  rgb2y_stream_if ifB ();
  rgb2y_stream_if ifC ();

  // 100 MHz clock
  always #5 clk = ~clk;

  assign ifA.din_valid = dinValid;
  assign ifA.din       = dinData;
  assign ifA.din_sof   = dinSof;
  assign ifB.din_valid = dinValid;
  assign ifB.din       = dinData;
  assign ifB.din_sof   = dinSof;
  assign ifC.din_valid = dinValid;
  assign ifC.din       = dinData;
  assign ifC.din_sof   = dinSof;

  rgb2y_stream #(.WIDTH(WA), .HEIGHT(HA)) dutA (
    .clk(clk), .nrst(nrst), .pix(ifA), .err_clr(errClr), .frame_err(errA)
  );
  rgb2y_stream #(.WIDTH(WB), .HEIGHT(HB)) dutB (
    .clk(clk), .nrst(nrst), .pix(ifB), .err_clr(errClr), .frame_err(errB)
  );
  rgb2y_stream #(.WIDTH(WC), .HEIGHT(HC)) dutC (
    .clk(clk), .nrst(nrst), .pix(ifC), .err_clr(errClr), .frame_err(errC)
  );

  assign obsY[0] = ifA.dout;       assign obsY[1] = ifB.dout;       assign obsY[2] = ifC.dout;
  assign obsV[0] = ifA.dout_valid; assign obsV[1] = ifB.dout_valid; assign obsV[2] = ifC.dout_valid;
  assign obsSof[0] = ifA.dout_sof; assign obsSof[1] = ifB.dout_sof; assign obsSof[2] = ifC.dout_sof;
  assign obsEol[0] = ifA.dout_eol; assign obsEol[1] = ifB.dout_eol; assign obsEol[2] = ifC.dout_eol;
  assign obsEof[0] = ifA.dout_eof; assign obsEof[1] = ifB.dout_eof; assign obsEof[2] = ifC.dout_eof;
  assign obsErr[0] = errA;         assign obsErr[1] = errB;         assign obsErr[2] = errC;

  function automatic int frameW(input int d);
    return (d == 0) ? WA : ((d == 1) ? WB : WC);
  endfunction

  function automatic int frameH(input int d);
    return (d == 0) ? HA : ((d == 1) ? HB : HC);
  endfunction

  function automatic logic [7:0] lumaRef(input logic [23:0] p);
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]) + 128;
    return 8'(s / 256);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [23:0] d, input logic s, input logic clr);
    @(posedge clk);
    #1;
    dinValid = v;
    dinData  = d;
    dinSof   = s;
    errClr   = clr;
  endtask

  // Reference model: a pixel's place in the frame is a linear index; outputs emerge three launches later
  always @(posedge clk or negedge nrst) begin
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      logic setErr;
      if (!nrst) begin
        inFrame[d] = 1'b0;
        pos[d]     = 0;
        expErr[d]  = 1'b0;
        heldY[d]   = 8'd0;
        for (int k = 0; k < 3; k++) hist[d][k] = '0;
      end else begin
        e      = '0;
        setErr = 1'b0;
        if (dinValid) begin
          if (dinSof) begin
            if (inFrame[d]) setErr = 1'b1;
            inFrame[d] = 1'b1;
            pos[d]     = 0;
          end else if (!inFrame[d]) begin
            setErr = 1'b1;
          end
          if (inFrame[d]) begin
            e.v   = 1'b1;
            e.y   = lumaRef(dinData);
            e.sof = (pos[d] == 0);
            e.eol = ((pos[d] % frameW(d)) == frameW(d) - 1);
            e.eof = (pos[d] == frameW(d) * frameH(d) - 1);
            pos[d]++;
            if (e.eof) begin
              inFrame[d] = 1'b0;
              pos[d]     = 0;
            end
          end
        end
        if (setErr) expErr[d] = 1'b1;
        else if (errClr) expErr[d] = 1'b0;
        hist[d][2] = hist[d][1];
        hist[d][1] = hist[d][0];
        hist[d][0] = e;
        if (hist[d][2].v) heldY[d] = hist[d][2].y;
      end
    end
  end

  // Compare every converter against the model mid-cycle and tally the observed frame flags
  always @(negedge clk) begin
    if (checkEn) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("d%0d_valid", d), 32'(obsV[d]), 32'(hist[d][2].v));
        checkOutput($sformatf("d%0d_dout", d), 32'(obsY[d]), 32'(heldY[d]));
        checkOutput($sformatf("d%0d_sof", d), 32'(obsSof[d]), 32'(hist[d][2].sof));
        checkOutput($sformatf("d%0d_eol", d), 32'(obsEol[d]), 32'(hist[d][2].eol));
        checkOutput($sformatf("d%0d_eof", d), 32'(obsEof[d]), 32'(hist[d][2].eof));
        checkOutput($sformatf("d%0d_frame_err", d), 32'(obsErr[d]), 32'(expErr[d]));
        if (obsEol[d] === 1'b1) eolCnt[d]++;
        if (obsEof[d] === 1'b1) eofCnt[d]++;
        if (obsSof[d] === 1'b1) sofCnt[d]++;
      end
    end
  end

  task automatic doReset();
    @(posedge clk);
    #1;
    nrst     = 1'b0;
    dinValid = 1'b0;
    dinSof   = 1'b0;
    errClr   = 1'b0;
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
    nrst = 1'b1;
  endtask

  // Directed scenarios followed by a randomized frame and a random stress phase
  initial begin
    logic [23:0] colors [5];
    logic [7:0]  lumas  [5];
    logic [23:0] px;
    int          e0;
    int          f0;
    int          s0;
    int          sent;
    int          valPat [7];

    colors = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF};
    lumas  = '{8'd255, 8'd0, 8'd77, 8'd149, 8'd29};
    valPat = '{1, 0, 1, 1, 0, 0, 1};
    for (int d = 0; d < 3; d++) begin
      eolCnt[d] = 0;
      eofCnt[d] = 0;
      sofCnt[d] = 0;
    end
    checkEn  = 1'b0;
    nrst     = 1'b0;
    dinValid = 1'b0;
    dinData  = 24'd0;
    dinSof   = 1'b0;
    errClr   = 1'b0;
    repeat (3) @(posedge clk);
    checkEn = 1'b1;
    #1;
    nrst = 1'b1;

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 24'hFFFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 24'(i * 24'h102030), 1'b0, 1'b0);
    checkOutput("pre_reset_valid", 32'(obsV[0]), 32'd1);
    nrst = 1'b0;
    #1;
    checkOutput("reset_valid", 32'(obsV[0]), 32'd0);
    checkOutput("reset_dout", 32'(obsY[0]), 32'd0);
    checkOutput("reset_err", 32'(obsErr[0]), 32'd0);
    applyStimulus(1'b1, 24'h123456, 1'b0, 1'b0);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    checkOutput("post_reset_nosof_valid", 32'(obsV[0]), 32'd0);
    checkOutput("post_reset_nosof_err", 32'(obsErr[0]), 32'd1);

    $display("[TB] single sof pixels");
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, colors[i], 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
      checkOutput($sformatf("color%0d_valid", i), 32'(obsV[0]), 32'd1);
      checkOutput($sformatf("color%0d_y", i), 32'(obsY[0]), 32'(lumas[i]));
      checkOutput($sformatf("color%0d_sof", i), 32'(obsSof[0]), 32'd1);
      checkOutput($sformatf("color%0d_err", i), 32'(obsErr[0]), (i == 0) ? 32'd0 : 32'd1);
    end

    $display("[TB] 4x2 frame");
    doReset();
    e0 = eolCnt[0];
    f0 = eofCnt[0];
    s0 = sofCnt[0];
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 24'($urandom), (i == 0), 1'b0);
    applyStimulus(1'b1, 24'($urandom), 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
    checkOutput("frame4x2_eol", 32'(eolCnt[0] - e0), 32'd2);
    checkOutput("frame4x2_eof", 32'(eofCnt[0] - f0), 32'd1);
    checkOutput("frame4x2_sof", 32'(sofCnt[0] - s0), 32'd1);
    checkOutput("frame4x2_drop_err", 32'(obsErr[0]), 32'd1);

    $display("[TB] bubble pattern");
    doReset();
    applyStimulus(1'b1, 24'h406080, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(valPat[i][0], 24'($urandom), 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);

    $display("[TB] early sof and error clear");
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 24'($urandom), (i == 0), 1'b0);
    applyStimulus(1'b1, 24'h00FF00, 1'b1, 1'b0);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
    checkOutput("early_sof_err", 32'(obsErr[0]), 32'd1);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
    checkOutput("early_sof_out_sof", 32'(obsSof[0]), 32'd1);
    checkOutput("early_sof_out_y", 32'(obsY[0]), 32'd149);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
    checkOutput("err_clr_alone", 32'(obsErr[0]), 32'd0);
    applyStimulus(1'b1, 24'h101010, 1'b1, 1'b1);
    applyStimulus(1'b1, 24'h202020, 1'b1, 1'b1);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
    checkOutput("err_clr_vs_set", 32'(obsErr[0]), 32'd1);

    $display("[TB] random frame on 16x12 geometry");
    doReset();
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b1);
    e0 = eolCnt[2];
    f0 = eofCnt[2];
    sent = 0;
    for (int c = 0; c < 2000 && sent < WC * HC; c++) begin
      if ($urandom_range(3) != 0) begin
        applyStimulus(1'b1, 24'($urandom), (sent == 0), 1'b0);
        sent++;
      end else begin
        applyStimulus(1'b0, 24'($urandom), 1'b0, 1'b0);
      end
    end
    repeat (5) applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
    checkOutput("frameC_pixels_sent", 32'(sent), 32'(WC * HC));
    checkOutput("frameC_eol", 32'(eolCnt[2] - e0), 32'(HC));
    checkOutput("frameC_eof", 32'(eofCnt[2] - f0), 32'd1);
    checkOutput("frameC_err", 32'(obsErr[2]), 32'd0);

    $display("[TB] random stress");
    for (int c = 0; c < 600; c++) begin
      px = 24'($urandom);
      applyStimulus(($urandom_range(4) != 0), px, ($urandom_range(40) == 0), ($urandom_range(30) == 0));
    end
    repeat (5) applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
